// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch front end: credit-limited request issue, in-order
// response capture into a small FIFO, and redirect flush with stale-response drop.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [63:0]   mem_q [DEPTH];

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    // Every buffered entry and every outstanding request holds one FIFO slot.
    assign credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_fire = imem_resp_valid && (inflight_q != '0);
    assign push      = resp_fire && (drop_q == '0) && !reset && !redirect_valid;

    assign dec_valid = !reset && !redirect_valid && (count_q != '0);
    assign pop       = dec_valid && dec_ready;
    assign dec_pc    = mem_q[rd_ptr_q][63:32];
    assign dec_instr = mem_q[rd_ptr_q][31:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still outstanding now belongs to the old path.
            fetch_pc_d = redirect_pc & ~32'd3;
            resp_pc_d  = redirect_pc & ~32'd3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = inflight_q - CW'(resp_fire);
            drop_d     = inflight_q - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire && (drop_q != '0)) begin
                drop_d = drop_q - ONE;
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {resp_pc_q, imem_resp_data};
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, directed corner sequences,
// and random traffic checked against a queue-based model of the fetch pipeline.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XORK     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: decode-visible entries, and the memory's outstanding requests in order.
    logic [63:0] ref_q[$];
    logic [31:0] out_addr[$];
    bit          out_stale[$];
    int          out_due[$];
    logic [31:0] m_fetch = RESET_PC;

    bit          k_rst, k_redir, k_rdy, k_drdy, k_resp_en, k_junk;
    logic [31:0] k_rpc;
    int          k_lat;

    bit          o_rv, o_fire, o_dv;
    logic [31:0] o_addr, o_pc;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        drdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        bit          rv;
        bit          rv_real;
        bit          e_rv;
        bit          e_dv;
        bit          s;
        logic [31:0] rd;
        logic [31:0] a;
        int          d;
        @(negedge clk);
        rv = 1'b0; rv_real = 1'b0; rd = '0;
        if (out_addr.size() != 0 && out_due[0] <= cyc && k_resp_en) begin
            rv = 1'b1; rv_real = 1'b1; rd = out_addr[0] ^ XORK;
        end else if (out_addr.size() == 0 && k_junk) begin
            rv = 1'b1; rd = $urandom;
        end
        reset           = k_rst;
        redirect_valid  = k_redir;
        redirect_pc     = k_rpc;
        imem_req_ready  = k_rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        dec_ready       = k_drdy;
        #1;
        e_rv = !k_rst && !k_redir && (ref_q.size() + out_addr.size() < DEPTH);
        e_dv = !k_rst && !k_redir && (ref_q.size() != 0);
        check("req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (e_rv) check("req_addr", imem_req_addr, m_fetch);
        check("dec_valid", 32'(dec_valid), 32'(e_dv));
        if (e_dv) begin
            check("dec_pc", dec_pc, ref_q[0][63:32]);
            check("dec_instr", dec_instr, ref_q[0][31:0]);
        end
        o_rv = imem_req_valid; o_fire = imem_req_valid && imem_req_ready;
        o_addr = imem_req_addr; o_dv = dec_valid; o_pc = dec_pc;
        if (k_rst) begin
            ref_q.delete(); out_addr.delete(); out_stale.delete(); out_due.delete();
            m_fetch = RESET_PC;
        end else if (k_redir) begin
            if (rv_real) begin
                a = out_addr.pop_front(); s = out_stale.pop_front(); d = out_due.pop_front();
            end
            foreach (out_stale[i]) out_stale[i] = 1'b1;
            ref_q.delete();
            m_fetch = k_rpc & ~32'd3;
        end else begin
            if (e_dv && k_drdy) void'(ref_q.pop_front());
            if (rv_real) begin
                a = out_addr.pop_front(); s = out_stale.pop_front(); d = out_due.pop_front();
                if (!s) ref_q.push_back({a, rd});
            end
            if (e_rv && k_rdy) begin
                out_addr.push_back(m_fetch); out_stale.push_back(1'b0); out_due.push_back(cyc + k_lat);
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic set_idle();
        k_rst = 0; k_redir = 0; k_rpc = '0; k_rdy = 1; k_drdy = 1;
        k_resp_en = 1; k_junk = 0; k_lat = 1;
    endtask

    task automatic do_reset();
        set_idle();
        k_rst = 1;
        run_cycle();
        run_cycle();
        k_rst = 0;
    endtask

    initial begin
        int          n_acc;
        int          n_pop;
        bit          got;
        logic [31:0] first_addr;
        logic [31:0] pcs[4];

        vecs[0]  = '{1, 0, 32'h0,  1, 0, 32'h0,         1, 0, 32'h0,  0, 32'h0,  32'h0};
        vecs[1]  = '{1, 0, 32'h0,  1, 0, 32'h0,         1, 0, 32'h0,  0, 32'h0,  32'h0};
        vecs[2]  = '{0, 0, 32'h0,  1, 0, 32'h0,         1, 1, 32'h0,  0, 32'h0,  32'h0};
        vecs[3]  = '{0, 0, 32'h0,  1, 1, 32'hA5A5_0000, 1, 1, 32'h4,  0, 32'h0,  32'h0};
        vecs[4]  = '{0, 0, 32'h0,  1, 1, 32'hA5A5_0004, 1, 1, 32'h8,  1, 32'h0,  32'hA5A5_0000};
        vecs[5]  = '{0, 0, 32'h0,  1, 1, 32'hA5A5_0008, 1, 1, 32'hC,  1, 32'h4,  32'hA5A5_0004};
        vecs[6]  = '{0, 0, 32'h0,  1, 1, 32'hA5A5_000C, 1, 1, 32'h10, 1, 32'h8,  32'hA5A5_0008};
        vecs[7]  = '{0, 1, 32'h43, 1, 1, 32'hA5A5_0010, 1, 0, 32'h0,  0, 32'h0,  32'h0};
        vecs[8]  = '{0, 0, 32'h0,  1, 0, 32'h0,         1, 1, 32'h40, 0, 32'h0,  32'h0};
        vecs[9]  = '{0, 0, 32'h0,  0, 1, 32'h1234_5678, 1, 1, 32'h44, 0, 32'h0,  32'h0};
        vecs[10] = '{0, 0, 32'h0,  0, 0, 32'h0,         0, 1, 32'h44, 1, 32'h40, 32'h1234_5678};
        vecs[11] = '{0, 0, 32'h0,  0, 1, 32'hDEAD_BEEF, 1, 1, 32'h44, 1, 32'h40, 32'h1234_5678};
        vecs[12] = '{0, 0, 32'h0,  0, 0, 32'h0,         1, 1, 32'h44, 0, 32'h0,  32'h0};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            imem_req_ready = vecs[i].rdy; imem_resp_valid = vecs[i].rv;
            imem_resp_data = vecs[i].rdata; dec_ready = vecs[i].drdy;
            #1;
            check("vec_req_valid", 32'(imem_req_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) check("vec_req_addr", imem_req_addr, vecs[i].e_addr);
            check("vec_dec_valid", 32'(dec_valid), 32'(vecs[i].e_dv));
            if (vecs[i].e_dv) begin
                check("vec_dec_pc", dec_pc, vecs[i].e_pc);
                check("vec_dec_instr", dec_instr, vecs[i].e_instr);
            end
        end

        // Decode stalled: fetch fills exactly DEPTH slots, then drains in order.
        do_reset();
        k_drdy = 0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            n_acc += int'(o_fire);
        end
        check("fill_accepts", n_acc, 4);
        check("fill_stall", 32'(o_rv), 32'd0);
        k_drdy = 1;
        n_pop = 0; got = 0; first_addr = '0;
        for (int i = 0; i < 12 && n_pop < 4; i++) begin
            run_cycle();
            if (o_rv && !got) begin got = 1; first_addr = o_addr; end
            if (o_dv) begin pcs[n_pop] = o_pc; n_pop++; end
        end
        check("drain_count", n_pop, 4);
        for (int i = 0; i < n_pop; i++) check("drain_pc", pcs[i], 32'(i * 4));
        check("resume_addr", first_addr, 32'h10);

        // Redirect with two requests outstanding and no response that cycle.
        do_reset();
        k_lat = 3;
        run_cycle();
        run_cycle();
        k_redir = 1; k_rpc = 32'h43;
        run_cycle();
        k_redir = 0;
        run_cycle();
        check("redir_req_valid", 32'(o_rv), 32'd1);
        check("redir_req_addr", o_addr, 32'h40);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            run_cycle();
            if (o_dv) begin got = 1; check("redir_first_pc", o_pc, 32'h40); end
        end
        check("redir_dec_seen", 32'(got), 32'd1);

        // Memory not ready: the pending address must hold.
        do_reset();
        k_rdy = 0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            n_acc += int'(o_fire);
            check("stall_addr", o_addr, RESET_PC);
        end
        check("stall_accepts", n_acc, 0);
        k_rdy = 1;
        run_cycle();
        k_rdy = 0;
        run_cycle();
        check("stall_next_addr", o_addr, RESET_PC + 32'd4);

        // Reset mid-stream with three buffered entries and one request outstanding.
        do_reset();
        k_drdy = 0;
        for (int i = 0; i < 20 && !(ref_q.size() == 3 && out_addr.size() == 1); i++) run_cycle();
        k_rst = 1;
        run_cycle();
        run_cycle();
        check("rst_dec_valid", 32'(o_dv), 32'd0);
        check("rst_req_valid", 32'(o_rv), 32'd0);
        k_rst = 0; k_junk = 1; k_drdy = 1;
        run_cycle();
        check("rst_first_addr", o_addr, RESET_PC);
        k_junk = 0;
        run_cycle();
        check("rst_no_stale", 32'(o_dv), 32'd0);
        run_cycle();
        check("rst_first_dec", 32'(o_dv), 32'd1);
        check("rst_first_pc", o_pc, RESET_PC);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            k_rst     = ($urandom_range(0, 99) == 0);
            k_redir   = ($urandom_range(0, 19) == 0);
            k_rpc     = $urandom;
            k_rdy     = ($urandom_range(0, 3) != 0);
            k_drdy    = ($urandom_range(0, 9) < 7);
            k_lat     = $urandom_range(1, 4);
            k_resp_en = ($urandom_range(0, 4) != 0);
            k_junk    = ($urandom_range(0, 9) == 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
